piso_tx: RTL and testbench

Parallel-in serial-out transmitter that sits directly upstream of the sipo stage. Its serial output `so` drives the sipo serial input `i`.
- Accepts WIDTH-bit words on a valid/ready handshake.
- Holds one word in a buffer while the previous word shifts out, so back-to-back words stream with no bubble when GAP=0.
- Marks the first bit of every word with `frame_start`, so the downstream stage can align word boundaries.

---
 rtl/piso_tx_if.sv | 8 +
 rtl/piso_tx.sv | 74 +++++++
 tb/tb_piso_tx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel word valid/ready handshake into the serializer
interface piso_tx_if #(parameter int WIDTH = 4) ();
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  modport master (output din, din_valid, input din_ready);
  modport slave (input din, din_valid, output din_ready);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: double-buffered parallel-in serial-out transmitter with frame marker
module piso_tx #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP = 0
) (
  input  logic clk,
  input  logic rst,
  piso_tx_if.slave bus,
  output logic so,
  output logic so_valid,
  output logic frame_start,
  output logic busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] buf_data, shreg, shifted;
  logic buf_full, accept, load, last;
  logic [CW-1:0] bit_cnt;
  logic [3:0] gap_cnt;
  assign accept = bus.din_valid && !buf_full;
  assign last = bit_cnt == LAST;
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign so_valid = state == S_SHIFT;
  assign so = so_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign frame_start = so_valid && bit_cnt == '0;
  assign busy = state != S_IDLE || buf_full;
  assign bus.din_ready = !buf_full;
  // next state and load decision; a load only ever happens with a full buffer
  always_comb begin
    state_d = state;
    load = 1'b0;
    case (state)
      S_IDLE: begin
        load = buf_full;
        state_d = buf_full ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: if (last) begin
        load = GAP == 0 && buf_full;
        state_d = GAP != 0 ? S_GAP : buf_full ? S_SHIFT : S_IDLE;
      end
      S_GAP: if (gap_cnt == '0) begin
        load = buf_full;
        state_d = buf_full ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_d;
  end
  // buffer, shifter and counters; bit_cnt clears on the last bit so odd widths wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_data <= '0;
      buf_full <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      buf_data <= accept ? bus.din : buf_data;
      buf_full <= load ? 1'b0 : accept ? 1'b1 : buf_full;
      shreg <= load ? buf_data : so_valid ? shifted : shreg;
      bit_cnt <= (load || (so_valid && last)) ? '0 : so_valid ? bit_cnt + 1'b1 : bit_cnt;
      gap_cnt <= (so_valid && last && GAP != 0) ? GAP_LOAD :
                 (state == S_GAP && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for three serializer configurations plus a sipo loopback model
module tb_piso_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  piso_tx_if #(.WIDTH(4)) ia ();
  piso_tx_if #(.WIDTH(4)) ig ();
  piso_tx_if #(.WIDTH(5)) ic ();
  logic a_so, a_sv, a_fs, a_busy;
  logic g_so, g_sv, g_fs, g_busy;
  logic c_so, c_sv, c_fs, c_busy;
  int total = 0, bad = 0, cyc = 0;
  logic [1:0] exp_a[$], exp_g[$], exp_c[$];
  logic [3:0] lb_q[$];
  logic [1:0] ea, eg, ec;
  int fp_a = -1, fp_g = -1, int_a = 0, int_g = 0;
  logic [3:0] sipo;
  int lb_n;
  logic lb_full;
  int lb_cnt = 0;
  int st;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u_a (
    .clk(clk), .rst(rst), .bus(ia.slave), .so(a_so), .so_valid(a_sv), .frame_start(a_fs), .busy(a_busy));
  piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP(2)) u_g (
    .clk(clk), .rst(rst), .bus(ig.slave), .so(g_so), .so_valid(g_sv), .frame_start(g_fs), .busy(g_busy));
  piso_tx #(.WIDTH(5), .MSB_FIRST(0), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .bus(ic.slave), .so(c_so), .so_valid(c_sv), .frame_start(c_fs), .busy(c_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic extra(input string n);
    total++;
    bad++;
    $display("FAIL %s got=unexpected_bit want=none t=%0t", n, $time);
  endtask

  function automatic logic rdy(input int d);
    return d == 0 ? ia.din_ready : d == 1 ? ig.din_ready : ic.din_ready;
  endfunction

  task automatic drive(input int d, input logic [31:0] w, input logic v);
    case (d)
      0: begin ia.din = w[3:0]; ia.din_valid = v; end
      1: begin ig.din = w[3:0]; ig.din_valid = v; end
      default: begin ic.din = w[4:0]; ic.din_valid = v; end
    endcase
  endtask

  task automatic push(input int d, input logic [31:0] w);
    if (d == 0) begin
      for (int i = 0; i < 4; i++) exp_a.push_back({i == 0, w[3-i]});
      lb_q.push_back(w[3:0]);
    end else if (d == 1) begin
      for (int i = 0; i < 4; i++) exp_g.push_back({i == 0, w[3-i]});
    end else begin
      for (int i = 0; i < 5; i++) exp_c.push_back({i == 0, w[i]});
    end
  endtask

  task automatic send(input int d, input logic [31:0] w, output int stalls);
    stalls = 0;
    drive(d, w, 1'b1);
    while (!rdy(d) && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!rdy(d)) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=ready_low want=ready_high dut=%0d", d);
      drive(d, w, 1'b0);
    end else begin
      @(posedge clk);
      push(d, w);
      @(negedge clk);
      drive(d, w, 1'b0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_a.size() + exp_g.size() + exp_c.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain", exp_a.size() + exp_g.size() + exp_c.size(), 0);
  endtask

  // scoreboard monitor for the GAP=0 MSB-first unit
  always @(negedge clk) if (rst) begin
    if (a_sv) begin
      if (exp_a.size() == 0) extra("a_extra");
      else begin
        ea = exp_a.pop_front();
        chk("a_so", a_so, ea[0]);
        chk("a_fs", a_fs, ea[1]);
      end
      if (a_fs) begin
        if (fp_a >= 0 && int_a != 0) chk("a_interval", cyc - fp_a, int_a);
        fp_a = cyc;
      end
    end else chk("a_idle", {a_so, a_fs}, 0);
  end

  // scoreboard monitor for the GAP=2 unit
  always @(negedge clk) if (rst) begin
    if (g_sv) begin
      if (exp_g.size() == 0) extra("g_extra");
      else begin
        eg = exp_g.pop_front();
        chk("g_so", g_so, eg[0]);
        chk("g_fs", g_fs, eg[1]);
      end
      if (g_fs) begin
        if (fp_g >= 0 && int_g != 0) chk("g_interval", cyc - fp_g, int_g);
        fp_g = cyc;
      end
    end else chk("g_idle", {g_so, g_fs}, 0);
  end

  // scoreboard monitor for the WIDTH=5 LSB-first unit
  always @(negedge clk) if (rst) begin
    if (c_sv) begin
      if (exp_c.size() == 0) extra("c_extra");
      else begin
        ec = exp_c.pop_front();
        chk("c_so", c_so, ec[0]);
        chk("c_fs", c_fs, ec[1]);
      end
    end else chk("c_idle", {c_so, c_fs}, 0);
  end

  // downstream sipo model fed by u_a, flags the cycle after each frame's 4th bit
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sipo <= '0;
      lb_n <= 0;
      lb_full <= 1'b0;
    end else begin
      if (a_sv) begin
        sipo <= {sipo[2:0], a_so};
        lb_n <= a_fs ? 1 : lb_n + 1;
      end
      lb_full <= a_sv && ((a_fs ? 1 : lb_n + 1) == 4);
    end
  end

  always @(negedge clk) if (rst && lb_full) begin
    if (lb_q.size() == 0) extra("loop_extra");
    else begin
      lb_cnt++;
      chk("loopback", sipo, lb_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    drive(2, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_a", {a_so, a_sv, a_fs, a_busy, ia.din_ready}, 5'b00001);
    chk("rst_g", {g_so, g_sv, g_fs, g_busy, ig.din_ready}, 5'b00001);
    chk("rst_c", {c_so, c_sv, c_fs, c_busy, ic.din_ready}, 5'b00001);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 4'b1011, st);
    chk("lat_before", a_sv, 0);
    @(negedge clk);
    chk("lat_first", {a_sv, a_fs, a_so}, 3'b111);
    drain();
    chk("idle_after", {a_sv, a_busy}, 0);
    fp_a = -1;
    int_a = 4;
    send(0, 4'hA, st);
    send(0, 4'h5, st);
    chk("stall_5", st, 1);
    send(0, 4'hF, st);
    chk("stall_F", st, 3);
    drain();
    int_a = 0;
    fp_g = -1;
    int_g = 6;
    send(1, 4'hC, st);
    send(1, 4'hC, st);
    drain();
    chk("g_idle_after", {g_sv, g_busy}, 0);
    int_g = 0;
    send(2, 5'b00110, st);
    send(2, 5'b10011, st);
    drain();
    send(0, 4'h9, st);
    send(0, 4'hF, st);
    #1 rst = 1'b0;
    #1 chk("rst_mid", {a_so, a_sv, a_fs, a_busy, ia.din_ready}, 5'b00001);
    exp_a.delete();
    lb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst", {a_sv, a_busy}, 0);
    send(0, 4'h3, st);
    send(0, 4'hE, st);
    drain();
    chk("loop_count", lb_cnt, 6);
    chk("loop_left", lb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
